draw_sprite_rom: RTL

//  Overlays one ROM-stored sprite onto the VGA pixel stream. Per pixel it computes
//  the sprite ROM address, drives image_rom (1-cycle read latency) and takes the

---
 rtl/draw_sprite_rom_pkg.sv | 27 ++
 rtl/draw_sprite_rom_delay.sv | 34 +++
 rtl/draw_sprite_rom.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/draw_sprite_rom_pkg.sv
// ============================================================================
// draw_sprite_rom_pkg : widths, timing-bus layout and stage latency shared by
//                       the draw_* overlay stages.
// Revision: 1.0
// ============================================================================
`default_nettype none

package draw_sprite_rom_pkg;

  localparam int PIX_W              = 11;
  localparam int RGB_W              = 12;
  localparam int DRAW_STAGE_LATENCY = 3;

  typedef struct packed {
    logic [PIX_W-1:0] hcount;
    logic [PIX_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

endpackage

`default_nettype wire

// File: rtl/draw_sprite_rom_delay.sv
// ============================================================================
// signal_delay : resettable shift register delaying a bus by CLK_DEL cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module signal_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [CLK_DEL-1:0][WIDTH-1:0] r_stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stage <= '0;
    end else begin
      r_stage[0] <= i_din;
      for (int i = 1; i < CLK_DEL; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_dout = r_stage[CLK_DEL-1];

endmodule

`default_nettype wire

// File: rtl/draw_sprite_rom.sv
// ============================================================================
// draw_sprite_rom : overlays one ROM sprite on the pixel stream, generating the
//                   ROM address and compositing the returned colour.
// Revision: 1.0
// ============================================================================
`default_nettype none

module draw_sprite_rom
  import draw_sprite_rom_pkg::*;
#(
  parameter int               IMG_WIDTH       = 128,
  parameter int               IMG_HEIGHT      = 128,
  parameter int               ADDR_WIDTH      = 14,
  parameter logic [RGB_W-1:0] TRANSPARENT_RGB = 12'hF0F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PIX_W-1:0]      hcount_in,
  input  logic [PIX_W-1:0]      vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  hblnk_in,
  input  logic                  vblnk_in,
  input  logic [RGB_W-1:0]      rgb_in,
  input  logic [PIX_W-1:0]      xpos,
  input  logic [PIX_W-1:0]      ypos,
  input  logic                  mirror_x,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [RGB_W-1:0]      rom_rgb,
  output logic [PIX_W-1:0]      hcount_out,
  output logic [PIX_W-1:0]      vcount_out,
  output logic                  hsync_out,
  output logic                  vsync_out,
  output logic                  hblnk_out,
  output logic                  vblnk_out,
  output logic [RGB_W-1:0]      rgb_out
);

  localparam logic [PIX_W:0]   c_IMG_W   = (PIX_W+1)'(IMG_WIDTH);
  localparam logic [PIX_W:0]   c_IMG_H   = (PIX_W+1)'(IMG_HEIGHT);
  localparam logic [PIX_W-1:0] c_COL_MAX = PIX_W'(IMG_WIDTH - 1);

  logic                  r_vblnk_prev;
  logic [PIX_W-1:0]      r_x;
  logic [PIX_W-1:0]      r_y;
  logic                  r_mirror;
  logic [ADDR_WIDTH-1:0] r_rom_addr;
  logic                  r_inside1;
  logic                  r_inside2;
  timing_t               r_tim_out;
  logic [RGB_W-1:0]      r_rgb_out;

  logic [PIX_W:0]        w_h12, w_v12, w_x12, w_y12;
  logic                  w_inside;
  logic [PIX_W-1:0]      w_dx, w_col, w_row;
  logic [ADDR_WIDTH-1:0] w_addr;
  timing_t               w_tim_in;
  timing_t               w_tim_d;
  logic [RGB_W-1:0]      w_rgb_d;
  logic                  w_use_bg;

  // Position is only taken at the start of vertical blanking to avoid tearing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vblnk_prev <= 1'b0;
      r_x          <= '0;
      r_y          <= '0;
      r_mirror     <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (vblnk_in && !r_vblnk_prev) begin
        r_x      <= xpos;
        r_y      <= ypos;
        r_mirror <= mirror_x;
      end
    end
  end

  // One extra bit keeps x+IMG_WIDTH from wrapping near the right edge.
  assign w_h12    = {1'b0, hcount_in};
  assign w_v12    = {1'b0, vcount_in};
  assign w_x12    = {1'b0, r_x};
  assign w_y12    = {1'b0, r_y};
  assign w_inside = (w_h12 >= w_x12) && (w_h12 < w_x12 + c_IMG_W) &&
                    (w_v12 >= w_y12) && (w_v12 < w_y12 + c_IMG_H);

  assign w_dx   = hcount_in - r_x;
  assign w_col  = r_mirror ? (c_COL_MAX - w_dx) : w_dx;
  assign w_row  = vcount_in - r_y;
  assign w_addr = ADDR_WIDTH'(w_row) * ADDR_WIDTH'(IMG_WIDTH) + ADDR_WIDTH'(w_col);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rom_addr <= '0;
      r_inside1  <= 1'b0;
      r_inside2  <= 1'b0;
    end else begin
      r_rom_addr <= w_inside ? w_addr : '0;
      r_inside1  <= w_inside;
      r_inside2  <= r_inside1;
    end
  end

  assign w_tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

  signal_delay #(
    .WIDTH   (TIMING_W + RGB_W),
    .CLK_DEL (DRAW_STAGE_LATENCY - 1)
  ) u_delay (
    .clk    (clk),
    .rst    (rst),
    .i_din  ({w_tim_in, rgb_in}),
    .o_dout ({w_tim_d, w_rgb_d})
  );

  assign w_use_bg = !r_inside2 || w_tim_d.hblnk || w_tim_d.vblnk ||
                    (rom_rgb == TRANSPARENT_RGB);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tim_out <= '0;
      r_rgb_out <= '0;
    end else begin
      r_tim_out <= w_tim_d;
      r_rgb_out <= w_use_bg ? w_rgb_d : rom_rgb;
    end
  end

  assign rom_addr   = r_rom_addr;
  assign hcount_out = r_tim_out.hcount;
  assign vcount_out = r_tim_out.vcount;
  assign hsync_out  = r_tim_out.hsync;
  assign vsync_out  = r_tim_out.vsync;
  assign hblnk_out  = r_tim_out.hblnk;
  assign vblnk_out  = r_tim_out.vblnk;
  assign rgb_out    = r_rgb_out;

endmodule

`default_nettype wire
